button_event_ctrl: RTL



---
 rtl/button_event_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/button_event_ctrl.sv
// Debounced push-button controller: 2-flop sync, per-button debounce FSM, sticky press events, maskable irq.
// Read data and irq are registered (1 cycle); the bus is always ready, so there is no backpressure.
module button_event_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [4:0]  button,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [11:0]      ADDR_LEVEL = 12'h078;
    localparam logic [11:0]      ADDR_PEND  = 12'h07C;
    localparam logic [11:0]      ADDR_MASK  = 12'h080;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {IDLE, CHANGING} state_t;

    logic [4:0]       sync_a;
    logic [4:0]       sync;
    state_t           state_q [5];
    state_t           state_d [5];
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       stable_q;
    logic [4:0]       stable_d;
    logic [4:0]       rise;
    logic [4:0]       pending_q;
    logic [4:0]       pending_d;
    logic [4:0]       mask_q;
    logic [4:0]       clr;
    logic             wdata_unused;

    assign wdata_unused = ^wdata[31:5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync   <= '0;
        end else begin
            sync_a <= button;
            sync   <= sync_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // The counter holds how many consecutive cycles sync has differed from stable.
    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        for (int i = 0; i < 5; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync[i] != stable_q[i]) begin
                        state_d[i] = CHANGING;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                CHANGING: begin
                    if (sync[i] == stable_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]  = IDLE;
                        cnt_d[i]    = '0;
                        stable_d[i] = sync[i];
                        rise[i]     = sync[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // A new event beats a simultaneous write-one-to-clear on the same bit.
    assign clr       = (we && addr == ADDR_PEND) ? wdata[4:0] : 5'b0;
    assign pending_d = (pending_q & ~clr) | rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q  <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            rdata     <= '0;
            irq       <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            pending_q <= pending_d;
            if (we && addr == ADDR_MASK) begin
                mask_q <= wdata[4:0];
            end
            irq <= |(pending_q & mask_q);
            case (addr)
                ADDR_LEVEL: rdata <= {27'b0, stable_q};
                ADDR_PEND:  rdata <= {27'b0, pending_q};
                ADDR_MASK:  rdata <= {27'b0, mask_q};
                default:    rdata <= '0;
            endcase
        end
    end

endmodule
